sha256_msg_padder: RTL and testbench

Front-end message padder that feeds the `sha_256` core. It accepts a message as a byte stream with a valid/ready handshake and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. It emits complete 512-bit blocks, each with its own valid/ready handshake, and flags the final block of each message. It sits between the message source and the hash core's block input.

---
 rtl/sha256_msg_padder.sv | 188 ++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - FIPS 180-4 byte-stream padder emitting 512-bit blocks to the sha_256 core.
// Optional per-message block index output under SHA256_PAD_BLKIDX_EN.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last
`ifdef SHA256_PAD_BLKIDX_EN
    ,
    output logic [15:0]  blk_index
`endif
);

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_EMIT,
        S_LENBLK
    } state_e;

    state_e           state_q, state_d;
    logic [6:0]       ptr_q, ptr_d;
    logic [LEN_W-1:0] bitcnt_q, bitcnt_d;
    logic [511:0]     buf_q, buf_d;
    logic             in_ready_q, in_ready_d;
    logic             blk_valid_q, blk_valid_d;
    logic             blk_last_q, blk_last_d;
    logic             len_pend_q, len_pend_d;
    logic             marker_pend_q, marker_pend_d;

    logic [63:0]      len64;
    logic [8:0]       byte_lsb;
    logic             in_hs;
    logic             blk_hs;

    assign len64    = 64'(bitcnt_q);
    // Byte k of the block lives at bits [511-8k -: 8]; ~ptr gives 63-k for k < 64.
    assign byte_lsb = {~ptr_q[5:0], 3'b000};
    assign in_hs    = in_valid & in_ready_q;
    assign blk_hs   = blk_valid_q & blk_ready;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        bitcnt_d      = bitcnt_q;
        buf_d         = buf_q;
        in_ready_d    = in_ready_q;
        blk_valid_d   = blk_valid_q;
        blk_last_d    = blk_last_q;
        len_pend_d    = len_pend_q;
        marker_pend_d = marker_pend_q;

        case (state_q)
            S_FILL: begin
                if (in_hs) begin
                    if (in_keep) begin
                        buf_d[byte_lsb +: 8] = in_data;
                        ptr_d                = ptr_q + 7'd1;
                        bitcnt_d             = bitcnt_q + LEN_W'(8);
                    end
                    if (in_last) begin
                        state_d    = S_PAD;
                        in_ready_d = 1'b0;
                    end else if (in_keep && ptr_q == 7'd63) begin
                        state_d     = S_EMIT;
                        in_ready_d  = 1'b0;
                        blk_valid_d = 1'b1;
                        blk_last_d  = 1'b0;
                    end
                end
            end

            S_PAD: begin
                state_d     = S_EMIT;
                blk_valid_d = 1'b1;
                if (ptr_q[6]) begin
                    // Block is full of data: marker and length both go to the extra block.
                    blk_last_d    = 1'b0;
                    len_pend_d    = 1'b1;
                    marker_pend_d = 1'b1;
                end else begin
                    buf_d[byte_lsb +: 8] = 8'h80;
                    if (ptr_q <= 7'd55) begin
                        buf_d[63:0] = len64;
                        blk_last_d  = 1'b1;
                    end else begin
                        blk_last_d    = 1'b0;
                        len_pend_d    = 1'b1;
                        marker_pend_d = 1'b0;
                    end
                end
            end

            S_EMIT: begin
                if (blk_hs) begin
                    blk_valid_d = 1'b0;
                    blk_last_d  = 1'b0;
                    buf_d       = '0;
                    ptr_d       = '0;
                    if (blk_last_q) begin
                        bitcnt_d   = '0;
                        state_d    = S_FILL;
                        in_ready_d = 1'b1;
                    end else if (len_pend_q) begin
                        state_d = S_LENBLK;
                    end else begin
                        state_d    = S_FILL;
                        in_ready_d = 1'b1;
                    end
                end
            end

            S_LENBLK: begin
                buf_d[511:504] = marker_pend_q ? 8'h80 : 8'h00;
                buf_d[63:0]    = len64;
                len_pend_d     = 1'b0;
                marker_pend_d  = 1'b0;
                blk_valid_d    = 1'b1;
                blk_last_d     = 1'b1;
                state_d        = S_EMIT;
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_FILL;
            ptr_q         <= '0;
            bitcnt_q      <= '0;
            buf_q         <= '0;
            in_ready_q    <= 1'b0;
            blk_valid_q   <= 1'b0;
            blk_last_q    <= 1'b0;
            len_pend_q    <= 1'b0;
            marker_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            bitcnt_q      <= bitcnt_d;
            buf_q         <= buf_d;
            in_ready_q    <= (state_d == S_FILL) ? 1'b1 : in_ready_d;
            blk_valid_q   <= blk_valid_d;
            blk_last_q    <= blk_last_d;
            len_pend_q    <= len_pend_d;
            marker_pend_q <= marker_pend_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_data  = buf_q;
    assign blk_last  = blk_last_q;

`ifdef SHA256_PAD_BLKIDX_EN
    logic [15:0] blk_idx_q, blk_idx_d;

    always_comb begin
        blk_idx_d = blk_idx_q;
        if (blk_hs) begin
            blk_idx_d = blk_last_q ? 16'd0 : blk_idx_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_idx_q <= '0;
        end else begin
            blk_idx_q <= blk_idx_d;
        end
    end

    assign blk_index = blk_idx_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - directed bench for sha256_msg_padder with a padded-block scoreboard.
module tb_sha256_msg_padder;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_keep;
    logic         in_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;
`ifdef SHA256_PAD_BLKIDX_EN
    logic [15:0]  blk_index;
`endif

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
`ifdef SHA256_PAD_BLKIDX_EN
        ,
        .blk_index (blk_index)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [15:0]  idx;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   msg_q[$];
    logic [511:0] last_obs;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        logic [7:0]  pb[$];
        logic [63:0] len;
        exp_t        e;
        int          nblk;
        pb  = msg_q;
        len = 64'(msg_q.size()) * 64'd8;
        pb.push_back(8'h80);
        while (pb.size() % 64 != 56) pb.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pb.push_back(len[8*i +: 8]);
        nblk = pb.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int j = 0; j < 64; j++) e.data[511 - 8*j -: 8] = pb[b*64 + j];
            e.last = (b == nblk - 1);
            e.idx  = 16'(b);
            exp_q.push_back(e);
        end
    endtask

    // lat_mode 1: final block latency; lat_mode 2: second block latency after first accept.
    task automatic run_msg(input bit empty, input int hold, input int lat_mode);
        int           beats, beat, cyc, last_hs_cyc, acc_cyc, nblk_seen, hold_left;
        bit           rdy_snap, prev_valid, new_blk;
        logic [511:0] held;
        exp_t         e;
        beats = empty ? 1 : msg_q.size();
        beat = 0; cyc = 0; rdy_snap = 0; prev_valid = 0; nblk_seen = 0;
        last_hs_cyc = -100; acc_cyc = -100; hold_left = hold; held = '0;
        push_expected();
        in_valid = 0; blk_ready = 0;
        while ((beat < beats || exp_q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (in_valid && rdy_snap) begin
                if (in_last) last_hs_cyc = cyc;
                beat++;
            end
            blk_ready = 0;
            new_blk = blk_valid && !prev_valid;
            if (new_blk) begin
                nblk_seen++;
                held = blk_data;
                if (lat_mode == 1 && exp_q.size() == 1) chk("final_latency", 512'(cyc - last_hs_cyc), 512'd1);
                if (lat_mode == 2 && nblk_seen == 2) chk("second_latency", 512'(cyc - acc_cyc), 512'd2);
            end
            if (hold_left > 0 && nblk_seen > 0) begin
                if (!new_blk) begin
                    chk("bp_valid", 512'(blk_valid), 512'd1);
                    chk("bp_data", blk_data, held);
                    chk("bp_in_ready", 512'(in_ready), 512'd0);
                    hold_left--;
                end
            end else if (blk_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_block", 512'(blk_valid), 512'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("blk_data", blk_data, e.data);
                    chk("blk_last", 512'(blk_last), 512'(e.last));
`ifdef SHA256_PAD_BLKIDX_EN
                    chk("blk_index", 512'(blk_index), 512'(e.idx));
`endif
                    last_obs  = blk_data;
                    blk_ready = 1;
                    acc_cyc   = cyc;
                end
            end
            prev_valid = blk_valid && !blk_ready;
            if (beat < beats) begin
                in_valid = 1;
                in_keep  = !empty;
                in_data  = empty ? 8'h00 : msg_q[beat];
                in_last  = (beat == beats - 1);
            end else begin
                in_valid = 0; in_keep = 0; in_last = 0; in_data = 8'h00;
            end
            rdy_snap = in_ready;
        end
        chk("pending_blocks", 512'(exp_q.size()), 512'd0);
        exp_q.delete();
        @(negedge clk);
        blk_ready = 0;
        chk("valid_drop", 512'(blk_valid), 512'd0);
        chk("in_ready_back", 512'(in_ready), 512'd1);
        msg_q.delete();
    endtask

    task automatic load_abc();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    logic [511:0] abc_blk;
    logic [511:0] empty_blk;

    initial begin
        abc_blk   = {32'h61626380, 416'h0, 64'h18};
        empty_blk = {8'h80, 504'h0};
        reset = 0; in_valid = 0; in_data = 0; in_keep = 0; in_last = 0; blk_ready = 0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 512'(in_ready), 512'd0);
        chk("rst_blk_valid", 512'(blk_valid), 512'd0);
        chk("rst_blk_last", 512'(blk_last), 512'd0);
        chk("rst_blk_data", blk_data, 512'd0);
        reset = 1;
        blk_ready = 1;
        @(negedge clk);
        chk("post_rst_in_ready", 512'(in_ready), 512'd1);
        @(negedge clk);
        chk("idle_ready_ignored", 512'(blk_valid), 512'd0);
        blk_ready = 0;

        load_abc();
        run_msg(0, 0, 1);
        chk("abc_const", last_obs, abc_blk);

        run_msg(1, 0, 1);
        chk("empty_const", last_obs, empty_blk);

        for (int i = 0; i < 55; i++) msg_q.push_back(8'h61);
        run_msg(0, 0, 1);
        chk("len55_tail", 512'(last_obs[71:0]), 512'({8'h80, 64'h1B8}));

        for (int i = 0; i < 56; i++) msg_q.push_back(8'h61);
        run_msg(0, 0, 2);
        chk("len56_tail", last_obs, 512'h1C0);

        for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom_range(0, 255)));
        run_msg(0, 0, 2);
        chk("len64_tail", last_obs, {8'h80, 440'h0, 64'h200});

        for (int i = 0; i < 130; i++) msg_q.push_back(8'($urandom_range(0, 255)));
        run_msg(0, 0, 0);

        load_abc();
        run_msg(0, 10, 0);

        for (int i = 0; i < 20; i++) begin
            in_valid = 1; in_keep = 1; in_last = 0; in_data = 8'(i + 1);
            @(negedge clk);
        end
        in_valid = 0;
        reset = 0;
        @(negedge clk);
        chk("mid_rst_blk_valid", 512'(blk_valid), 512'd0);
        chk("mid_rst_in_ready", 512'(in_ready), 512'd0);
        chk("mid_rst_blk_data", blk_data, 512'd0);
        reset = 1;
        @(negedge clk);
        load_abc();
        run_msg(0, 0, 1);
        chk("abc_after_rst", last_obs, abc_blk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
